// File: rtl/strip_placer_pkg.sv
// strip_placer_pkg: strip geometry tables, their derivation and the result record for strip_placer_param
// No ports. STRIP_H lists strip heights bottom-up; STRIP_Y is the y origin of each strip.
package strip_placer_pkg;
    localparam int NUM_STRIPS_DEF = 14;
    localparam int COORD_W_DEF = 8;
    localparam int TBL_W = 8;

    typedef logic [NUM_STRIPS_DEF-1:0][TBL_W-1:0] tbl_t;

    localparam tbl_t STRIP_H = {8'd17, 8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11,
                                8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4};

    // Strips are stacked with no gap, so each origin is the running sum of the heights below it.
    function automatic tbl_t calc_strip_y(tbl_t hgt);
        tbl_t y;
        logic [TBL_W-1:0] acc;
        acc = '0;
        for (int j = 0; j < NUM_STRIPS_DEF; j++) begin
            y[j] = acc;
            acc = acc + hgt[j];
        end
        return y;
    endfunction

    localparam tbl_t STRIP_Y = calc_strip_y(STRIP_H);

    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic                   strike_flag;
    } result_t;
endpackage

// File: rtl/strip_placer_param_if.sv
// strip_placer_param_if: request/result handshake bundle of strip_placer_param
// Request: in_valid_i/in_ready_o with width_i/height_i. Result: out_valid_o/out_ready_i with
// index_x_o/index_y_o, strike_flag_o and the cumulative strike_o. slave = placer, master = client.
interface strip_placer_param_if #(
    parameter int DIM_W    = 5,
    parameter int COORD_W  = 8,
    parameter int STRIKE_W = 4
);
    logic                in_valid_i;
    logic                in_ready_o;
    logic [DIM_W-1:0]    width_i;
    logic [DIM_W-1:0]    height_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [COORD_W-1:0]  index_x_o;
    logic [COORD_W-1:0]  index_y_o;
    logic                strike_flag_o;
    logic [STRIKE_W-1:0] strike_o;

    modport master (
        output in_valid_i, width_i, height_i, out_ready_i,
        input  in_ready_o, out_valid_o, index_x_o, index_y_o, strike_flag_o, strike_o
    );

    modport slave (
        input  in_valid_i, width_i, height_i, out_ready_i,
        output in_ready_o, out_valid_o, index_x_o, index_y_o, strike_flag_o, strike_o
    );
endinterface

// File: rtl/strip_select.sv
// strip_select: combinational best-fit strip choice for one rectangle
// occ_i: per-strip occupancy; width_i/height_i: rectangle; hit_o: some strip fits;
// index_o: chosen strip (smallest height, then smallest occupancy, then lowest index); x_o: its occupancy.
module strip_select
    import strip_placer_pkg::*;
#(
    parameter int NUM_STRIPS = NUM_STRIPS_DEF,
    parameter int CANVAS_W   = 128,
    parameter int DIM_W      = 5,
    parameter int COORD_W    = 8,
    parameter int IDX_W      = $clog2(NUM_STRIPS)
) (
    input  logic [NUM_STRIPS-1:0][COORD_W-1:0] occ_i,
    input  logic [DIM_W-1:0]                   width_i,
    input  logic [DIM_W-1:0]                   height_i,
    output logic                               hit_o,
    output logic [IDX_W-1:0]                   index_o,
    output logic [COORD_W-1:0]                 x_o
);
    always_comb begin
        hit_o = 1'b0;
        index_o = '0;
        // Strict comparisons keep the earlier (lower) index on a full tie.
        for (int j = 0; j < NUM_STRIPS; j++)
            if (|width_i && |height_i && int'(STRIP_H[j]) >= int'(height_i) &&
                ({1'b0, occ_i[j]} + (COORD_W+1)'(width_i) <= (COORD_W+1)'(CANVAS_W)) &&
                (!hit_o || STRIP_H[j] < STRIP_H[index_o] ||
                 (STRIP_H[j] == STRIP_H[index_o] && occ_i[j] < occ_i[index_o]))) begin
                hit_o = 1'b1;
                index_o = IDX_W'(j);
            end
        x_o = occ_i[index_o];
    end
endmodule

// File: rtl/strip_placer_param.sv
// strip_placer_param: handshaked best-fit strip placement engine with strike counting
// clk_i/rst_i: clock and synchronous active-high reset; clear_i: new canvas and strike counter zero;
// bus (slave): request in, placement result (x, y, strike flag, cumulative strikes) out.
module strip_placer_param
    import strip_placer_pkg::*;
#(
    parameter int NUM_STRIPS = NUM_STRIPS_DEF,
    parameter int CANVAS_W   = 128,
    parameter int DIM_W      = 5,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int STRIKE_W   = 4
) (
    input logic clk_i,
    input logic rst_i,
    input logic clear_i,
    strip_placer_param_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_STRIPS);

    logic [NUM_STRIPS-1:0][COORD_W-1:0] occ_q, occ_d, occ_eff;
    logic [STRIKE_W-1:0] cnt_q, cnt_d, cnt_eff, strike_q, strike_d;
    logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
    logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
    result_t res_q, res_d;
    logic adv, hit;
    logic [IDX_W-1:0] idx;
    logic [COORD_W-1:0] x;

    assign adv = !out_valid_q || bus.out_ready_i;
    assign bus.in_ready_o = adv && !rst_i;
    assign bus.out_valid_o = out_valid_q;
    assign bus.index_x_o = res_q.x;
    assign bus.index_y_o = res_q.y;
    assign bus.strike_flag_o = res_q.strike_flag;
    assign bus.strike_o = strike_q;

    // A clear on the commit edge means the commit sees an empty canvas and a zero counter.
    assign occ_eff = clear_i ? '0 : occ_q;
    assign cnt_eff = clear_i ? '0 : cnt_q;

    strip_select #(
        .NUM_STRIPS(NUM_STRIPS), .CANVAS_W(CANVAS_W), .DIM_W(DIM_W), .COORD_W(COORD_W), .IDX_W(IDX_W)
    ) u_sel (
        .occ_i(occ_eff), .width_i(w_q), .height_i(h_q), .hit_o(hit), .index_o(idx), .x_o(x)
    );

    always_comb begin
        occ_d = occ_eff;
        cnt_d = cnt_eff;
        s1_valid_d = s1_valid_q;
        w_d = w_q;
        h_d = h_q;
        out_valid_d = out_valid_q;
        res_d = res_q;
        strike_d = strike_q;
        if (adv) begin
            s1_valid_d = bus.in_valid_i;
            w_d = bus.width_i;
            h_d = bus.height_i;
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d.x = hit ? x : '0;
                res_d.y = hit ? COORD_W_DEF'(STRIP_Y[idx]) : '0;
                res_d.strike_flag = !hit;
                if (hit)
                    occ_d[idx] = occ_eff[idx] + COORD_W'(w_q);
                else if (cnt_eff != '1)
                    cnt_d = cnt_eff + STRIKE_W'(1);
                strike_d = cnt_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q <= '0;
            cnt_q <= '0;
            s1_valid_q <= 1'b0;
            w_q <= '0;
            h_q <= '0;
            out_valid_q <= 1'b0;
            res_q <= '0;
            strike_q <= '0;
        end else begin
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            s1_valid_q <= s1_valid_d;
            w_q <= w_d;
            h_q <= h_d;
            out_valid_q <= out_valid_d;
            res_q <= res_d;
            strike_q <= strike_d;
        end
    end
endmodule

// File: tb/tb_strip_placer_param.sv
// tb_strip_placer_param: directed literal checks plus randomized traffic against a behavioural placement model
module tb_strip_placer_param;
    logic clk = 1'b0;
    logic rst, clear;
    int cmp = 0;
    int fails = 0;

    strip_placer_param_if bus ();
    strip_placer_param dut (.clk_i(clk), .rst_i(rst), .clear_i(clear), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        cmp++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Strip j has height 4+j; strips are stacked, so its origin is sum_{i<j}(4+i).
    function automatic int hgt(int j);
        return 4 + j;
    endfunction

    function automatic int ypos(int j);
        return 4 * j + j * (j - 1) / 2;
    endfunction

    int occ[14];
    int cnt;
    bit m_ov, m_s1;
    int s1w, s1h, ex, ey, ef, es;

    always @(posedge clk) begin : model
        bit adv;
        int best;
        if (rst) begin
            foreach (occ[j]) occ[j] = 0;
            cnt = 0; m_ov = 0; m_s1 = 0; ex = 0; ey = 0; ef = 0; es = 0;
        end else begin
            if (clear) begin
                foreach (occ[j]) occ[j] = 0;
                cnt = 0;
            end
            adv = !m_ov || bus.out_ready_i;
            if (adv) begin
                if (m_s1) begin
                    best = -1;
                    for (int j = 0; j < 14; j++)
                        if (s1w > 0 && s1h > 0 && s1h <= hgt(j) && occ[j] + s1w <= 128 &&
                            (best < 0 || hgt(j) < hgt(best) || (hgt(j) == hgt(best) && occ[j] < occ[best])))
                            best = j;
                    if (best >= 0) begin
                        ex = occ[best]; ey = ypos(best); ef = 0;
                        occ[best] += s1w;
                    end else begin
                        ex = 0; ey = 0; ef = 1;
                        cnt = (cnt < 15) ? cnt + 1 : 15;
                    end
                    es = cnt;
                end
                m_ov = m_s1;
                m_s1 = bus.in_valid_i;
                s1w = int'(bus.width_i);
                s1h = int'(bus.height_i);
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", int'(bus.in_ready_o), int'(!rst && (!m_ov || bus.out_ready_i)));
        chk("out_valid", int'(bus.out_valid_o), int'(m_ov));
        if (m_ov) begin
            chk("x", int'(bus.index_x_o), ex);
            chk("y", int'(bus.index_y_o), ey);
            chk("strike_flag", int'(bus.strike_flag_o), ef);
            chk("strike", int'(bus.strike_o), es);
        end
    end

    // Starts just after a rising edge with out_ready high; returns just after the commit edge.
    task automatic send(int w, int h, int xx, int yy, int ff, int ss, bit clr);
        bus.in_valid_i = 1'b1;
        bus.width_i = 5'(w);
        bus.height_i = 5'(h);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        clear = clr;
        chk("lat_idle", int'(bus.out_valid_o), 0);
        @(posedge clk); #1;
        clear = 1'b0;
        chk("lit_valid", int'(bus.out_valid_o), 1);
        chk("lit_x", int'(bus.index_x_o), xx);
        chk("lit_y", int'(bus.index_y_o), yy);
        chk("lit_flag", int'(bus.strike_flag_o), ff);
        chk("lit_strike", int'(bus.strike_o), ss);
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.width_i = '0;
        bus.height_i = '0;
        bus.out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready_o), 0);
        chk("rst_out_valid", int'(bus.out_valid_o), 0);
        chk("rst_x", int'(bus.index_x_o), 0);
        chk("rst_y", int'(bus.index_y_o), 0);
        chk("rst_flag", int'(bus.strike_flag_o), 0);
        chk("rst_strike", int'(bus.strike_o), 0);
        rst = 1'b0;

        send(10, 4, 0, 0, 0, 0, 0);
        send(10, 4, 10, 0, 0, 0, 0);
        for (int i = 2; i < 12; i++) send(10, 4, 10 * i, 0, 0, 0, 0);
        send(8, 4, 120, 0, 0, 0, 0);
        send(1, 4, 0, 4, 0, 0, 0);
        send(5, 18, 0, 0, 1, 1, 0);
        send(0, 3, 0, 0, 1, 2, 0);
        send(5, 0, 0, 0, 1, 3, 0);
        for (int i = 4; i < 20; i++) send(1, 20, 0, 0, 1, (i > 15) ? 15 : i, 0);
        send(6, 4, 0, 0, 0, 0, 1);
        send(6, 4, 6, 0, 0, 0, 0);
        send(0, 4, 0, 0, 1, 1, 0);

        bus.in_valid_i = 1'b1;
        bus.width_i = 5'd5;
        bus.height_i = 5'd4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst2_out_valid", int'(bus.out_valid_o), 0);
        chk("rst2_strike", int'(bus.strike_o), 0);
        send(3, 4, 0, 0, 0, 0, 0);

        bus.out_ready_i = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.width_i = 5'd2;
        bus.height_i = 5'd5;
        repeat (6) @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        bus.in_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 800; i++) begin
            bus.in_valid_i = $urandom_range(0, 3) != 0;
            bus.width_i = 5'($urandom_range(0, 24));
            bus.height_i = 5'($urandom_range(0, 18));
            bus.out_ready_i = $urandom_range(0, 3) != 0;
            clear = $urandom_range(0, 49) == 0;
            @(posedge clk); #1;
        end
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        clear = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", cmp, fails);
        $finish;
    end
endmodule

// File: doc/strip_placer_param.md
Name: strip_placer_param

Overview:
- Parametrised, handshaked successor of the rectangle-filling placement engine.
- Accepts one rectangle (width, height) per transfer and selects a horizontal strip of the canvas for it, using best-fit on strip height.
- Returns the placement origin (x, y), or a strike when no strip can hold the rectangle.
- Strip count, canvas width, dimension widths and the strip-height table are generic. Per-strip occupancy uses atomic read-modify-write, so back-to-back requests never read stale occupancy.

Parameters:
- NUM_STRIPS, 14, number of strips. Must equal the length of the package strip-height table.
- CANVAS_W, 128, usable width of every strip.
- DIM_W, 5, width of the rectangle width and height inputs.
- COORD_W, 8, width of x/y outputs and of per-strip occupancy. Requires CANVAS_W < 2**COORD_W.
- STRIKE_W, 4, width of the cumulative strike counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  one-cycle pulse; empties every strip (new canvas) and zeroes the strike counter.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o.
- width_i  in  DIM_W  rectangle width.
- height_i  in  DIM_W  rectangle height.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result consumed when out_valid_o && out_ready_i.
- index_x_o  out  COORD_W  placement x (0 on strike).
- index_y_o  out  COORD_W  placement y (0 on strike).
- strike_flag_o  out  1  this result is a strike.
- strike_o  out  STRIKE_W  cumulative strikes, including the current result.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state: occupancy[all] = 0, S1 empty, out_valid_o = 0, index_x_o = 0, index_y_o = 0, strike_flag_o = 0, strike_o = 0.
- Reset mid-operation drops in-flight requests with no output. in_ready_o = 0 during the reset cycle.
- Pipeline:
  - adv = !out_valid_o || out_ready_i.
  - in_ready_o = adv.
  - Stage S1 register holds an accepted request (s1_valid, w, h).
  - On a clock edge with adv: S1 loads the input handshake (s1_valid <= in_valid_i). If s1_valid was set, the request commits and loads the output register, out_valid_o <= 1. Otherwise out_valid_o <= 0.
  - On an edge without adv, everything holds; outputs are stable while stalled.
- Latency: accepted at edge k, result visible after edge k+1 with no backpressure. Throughput is 1 per cycle.
- Commit (combinational in S1, registered on adv):
  - Eligible strip j: STRIP_H[j] >= h AND occupancy[j] + w <= CANVAS_W. The sum is computed at COORD_W+1 bits. An exact fit is eligible.
  - Selection: smallest STRIP_H among eligible strips. Tie-break on smallest occupancy, then lowest index.
  - Hit: x = occupancy[j], y = STRIP_Y[j], occupancy[j] <= occupancy[j] + w, strike_flag = 0.
  - Strike: no eligible strip, or w == 0, or h == 0. Then x = y = 0, strike_flag = 1, no occupancy write, counter += 1, saturating at 2**STRIKE_W-1.
  - strike_o carries the counter value after this result's increment.
- Back-to-back requests to the same strip: the occupancy update is atomic in the commit cycle, so the next request sees the new value. No forwarding path is needed.
- clear_i:
  - Acts on its edge regardless of adv: zero occupancy and the counter.
  - If a commit happens on the same edge, the commit is evaluated against the cleared canvas (counter = 0 before its increment).
  - The output register and S1 are not flushed.
- Result ordering is strictly in request order. No request is dropped while rst_i = 0.

Decomposition:
- Package strip_placer_pkg holds:
  - STRIP_H table, default 4,5,...,17.
  - STRIP_Y table (cumulative sums: 0,4,9,15,...).
  - A function computing STRIP_Y from STRIP_H.
  - A result struct {x, y, strike_flag}.
- One sub-module, strip_select: purely combinational eligibility and best-fit arg-min over NUM_STRIPS. Outputs hit, index, and x.
- Top level holds the occupancy array, S1, the output register, the counter and the handshake.

Test Plan:
- Reset, then w=10,h=4 → x=0,y=0,flag=0, out_valid one edge after acceptance. Then w=10,h=4 again back-to-back → x=10,y=0.
- Twelve w=10,h=4 fill strip0 to 120. Then w=8,h=4 → x=120,y=0 (exact fit to 128). Then w=1,h=4 → strip1: x=0,y=4.
- h=18, then w=0,h=3, then h=0 → three strikes with x=y=0, strike_o = 1,2,3. Sixteen further strikes → strike_o saturates at 15.
- out_ready_i=0 for 5 cycles with valid output → outputs stable, in_ready_o=0, no occupancy change. Release → results in order, none lost.
- clear_i on the same edge as the commit of w=6,h=4 after strip0 was filled → result x=0,y=0, strike_o=0. Next w=6,h=4 → x=6.
- rst_i asserted while S1 and the output are valid → next cycle out_valid_o=0, strike_o=0. First post-reset w=3,h=4 → x=0,y=0.
